// File: rtl/lz_arb_pkg.sv
// Shared definitions for the lowest-zero priority arbiter.
//   arb_state_e : arbiter FSM states (idle / grant held)
//   MODE_FIXED  : fixed MSB-first priority
//   MODE_RR     : round-robin priority starting at rr_ptr
//   idx_to_pos  : maps a grant index (counted from the MSB) to its req_n bit position
package lz_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index 0 is the MSB of req_n, index n-1 is bit 0.
  function automatic int unsigned idx_to_pos(input int unsigned idx, input int unsigned n);
    return n - 1 - idx;
  endfunction

endpackage

// File: rtl/lz_prio_pick.sv
// Combinational rotating first-zero finder.
//   req_n : active-low requests, bit N-1 is index 0
//   start : index at which the search begins (wraps from N-1 to 0)
//   excl  : active-high mask in req_n bit positions; masked channels never win
//   found : some non-excluded channel is requesting
//   idx   : first requesting index at or after start (0 when found=0)
module lz_prio_pick
  import lz_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_n,
  input  logic [W-1:0] start,
  input  logic [N-1:0] excl,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam int WP = W + 1;

  // Candidates re-ordered so that cand[i] belongs to grant index i.
  logic [N-1:0]  cand;
  // One extra bit: start + k reaches at most 2N-2 before the wrap.
  logic [WP-1:0] pos;

  for (genvar i = 0; i < N; i++) begin : g_cand
    assign cand[i] = ~req_n[idx_to_pos(i, N)] & ~excl[idx_to_pos(i, N)];
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + WP'(k);
      // Wrap at N rather than 2^W so non-power-of-2 N never yields idx >= N.
      if (pos >= WP'(N)) pos = pos - WP'(N);
      if (!found && cand[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/lz_prio_arbiter.sv
// Registered N-channel lowest-zero priority arbiter with optional round-robin
// and a bounded hold limit.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req_n      : active-low requests; req_n[N-1] is index 0
//   gnt_valid  : a grant is active
//   gnt_idx    : granted index counted from the MSB
//   gnt_onehot : active-high grant in req_n bit positions, zero when idle
// Handshake: there is no ready; a channel keeps its grant for as long as it
// holds its req_n bit low, except that with MAX_HOLD != 0 the grant is taken
// away after MAX_HOLD cycles if another channel is waiting. All outputs are
// registered (or decoded from registers only), never combinational from req_n.
// Internal state (state_q, rr_ptr, hold_cnt) is kept as named signals so
// checkers can bind to it.
module lz_prio_arbiter
  import lz_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = $clog2(N),
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_n,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  arb_state_e    state_q, state_d;
  logic [W-1:0]  rr_ptr, rr_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          valid_d;
  logic [W-1:0]  idx_d;

  logic [W-1:0]  pick_start;
  logic [N-1:0]  pick_excl;
  logic          pick_found;
  logic [W-1:0]  pick_idx;
  logic          released;
  logic          at_limit;
  logic          take;

  lz_prio_pick #(.N(N), .W(W)) u_pick (
    .req_n (req_n),
    .start (pick_start),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  for (genvar i = 0; i < N; i++) begin : g_onehot
    assign gnt_onehot[idx_to_pos(i, N)] = gnt_valid && (gnt_idx == W'(i));
  end

  always_comb begin
    pick_start = (MODE == MODE_RR) ? rr_ptr : '0;
    // The granted channel has dropped its request.
    released   = ~|(~req_n & gnt_onehot);
    at_limit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    // Only a timeout (not a release) excludes the current holder.
    pick_excl  = (state_q == ST_GRANT && !released && at_limit) ? gnt_onehot : '0;
  end

  always_comb begin
    state_d = state_q;
    valid_d = gnt_valid;
    idx_d   = gnt_idx;
    rr_d    = rr_ptr;
    hold_d  = hold_cnt;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: take = pick_found;
      ST_GRANT: begin
        if (released) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end else if (at_limit) begin
          // Nobody else waiting: keep the grant and start a fresh window.
          if (pick_found) take = 1'b1;
          else            hold_d = '0;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_GRANT;
      valid_d = 1'b1;
      idx_d   = pick_idx;
      hold_d  = '0;
      rr_d    = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_valid <= valid_d;
      gnt_idx   <= idx_d;
      rr_ptr    <= rr_d;
      hold_cnt  <= hold_d;
    end
  end

endmodule

// File: tb/tb_lz_prio_arbiter.sv
module tb_lz_prio_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req4;
  logic [4:0] req5;
  bit         live = 1'b0;

  logic       v0, v1, v2, v3, v4;
  logic [1:0] i0, i1, i2;
  logic [2:0] i3, i4;
  logic [3:0] o0, o1, o2;
  logic [4:0] o3, o4;

  lz_prio_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u0 (
    .clk(clk), .rst(rst), .req_n(req4), .gnt_valid(v0), .gnt_idx(i0), .gnt_onehot(o0));
  lz_prio_arbiter #(.N(4), .MODE(1), .MAX_HOLD(4)) u1 (
    .clk(clk), .rst(rst), .req_n(req4), .gnt_valid(v1), .gnt_idx(i1), .gnt_onehot(o1));
  lz_prio_arbiter #(.N(4), .MODE(1), .MAX_HOLD(2)) u2 (
    .clk(clk), .rst(rst), .req_n(req4), .gnt_valid(v2), .gnt_idx(i2), .gnt_onehot(o2));
  lz_prio_arbiter #(.N(5), .MODE(0), .MAX_HOLD(3)) u3 (
    .clk(clk), .rst(rst), .req_n(req5), .gnt_valid(v3), .gnt_idx(i3), .gnt_onehot(o3));
  lz_prio_arbiter #(.N(5), .MODE(1), .MAX_HOLD(0)) u4 (
    .clk(clk), .rst(rst), .req_n(req5), .gnt_valid(v4), .gnt_idx(i4), .gnt_onehot(o4));

  int p_n[5]    = '{4, 4, 4, 5, 5};
  int p_mode[5] = '{0, 1, 1, 0, 1};
  int p_hold[5] = '{0, 4, 2, 3, 0};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // onehot must always be the gated decode of the index
  always @(negedge clk) begin
    if (live) begin
      total++;
      assert (o0 === (v0 ? (4'b1000 >> i0) : 4'b0000) &&
              o1 === (v1 ? (4'b1000 >> i1) : 4'b0000) &&
              o2 === (v2 ? (4'b1000 >> i2) : 4'b0000) &&
              o3 === (v3 ? (5'b10000 >> i3) : 5'b00000) &&
              o4 === (v4 ? (5'b10000 >> i4) : 5'b00000))
      else begin
        bad++;
        $display("FAIL onehot_consistency: o0=%b o1=%b o2=%b o3=%b o4=%b", o0, o1, o2, o3, o4);
      end
    end
  end

  // ---------------- reference model ----------------
  // Grant history described as: who holds, for how many cycles, and where the
  // round-robin search begins next time.
  typedef struct {
    bit v;
    int idx;
    int rr;
    int hold;
  } mdl_t;

  mdl_t mdl[5];

  function automatic int choose(input int n, input logic [7:0] rq, input int start, input int excl);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (start + k) % n;
      if (rq[n-1-c] == 1'b0 && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic mdl_t ref_next(input mdl_t m, input int n, input int mode, input int maxh,
                                    input logic [7:0] rq, input bit r);
    mdl_t q;
    int   w;
    int   start;
    q = m;
    if (r) begin
      q.v = 0; q.idx = 0; q.rr = 0; q.hold = 0;
      return q;
    end
    start = (mode == 1) ? m.rr : 0;
    w = -1;
    if (!m.v) begin
      w = choose(n, rq, start, -1);
    end else if (rq[n-1-m.idx] == 1'b1) begin
      w = choose(n, rq, start, -1);
      if (w < 0) begin q.v = 0; q.idx = 0; end
    end else if (maxh != 0 && m.hold == maxh - 1) begin
      w = choose(n, rq, start, m.idx);
      if (w < 0) q.hold = 0;
    end else if (maxh != 0) begin
      q.hold = m.hold + 1;
    end
    if (w >= 0) begin
      q.v = 1; q.idx = w; q.rr = (w + 1) % n; q.hold = 0;
    end
    return q;
  endfunction

  task automatic cmp(input int id, input logic vv, input logic [2:0] ii, input logic [7:0] oo);
    int n;
    logic [7:0] eoh;
    n = p_n[id];
    eoh = mdl[id].v ? (8'd1 << (n - 1 - mdl[id].idx)) : 8'd0;
    check($sformatf("rnd_u%0d_valid", id), 32'(vv), 32'(mdl[id].v));
    check($sformatf("rnd_u%0d_idx", id), 32'(ii), 32'(mdl[id].idx));
    check($sformatf("rnd_u%0d_onehot", id), 32'(oo), 32'(eoh));
  endtask

  // ---------------- directed vectors (u0: fixed priority) ----------------
  typedef struct {
    logic [3:0] req;
    logic       v;
    logic [1:0] idx;
    logic [3:0] oh;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{4'b0111, 1'b1, 2'd0, 4'b1000};
    tbl[1]  = '{4'b1111, 1'b0, 2'd0, 4'b0000};
    tbl[2]  = '{4'b1011, 1'b1, 2'd1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 2'd0, 4'b0000};
    tbl[4]  = '{4'b1101, 1'b1, 2'd2, 4'b0010};
    tbl[5]  = '{4'b1111, 1'b0, 2'd0, 4'b0000};
    tbl[6]  = '{4'b1110, 1'b1, 2'd3, 4'b0001};
    tbl[7]  = '{4'b1111, 1'b0, 2'd0, 4'b0000};
    tbl[8]  = '{4'b0111, 1'b1, 2'd0, 4'b1000};
    tbl[9]  = '{4'b1010, 1'b1, 2'd1, 4'b0100};  // release, no bubble
    tbl[10] = '{4'b1010, 1'b1, 2'd1, 4'b0100};  // unlimited hold
    tbl[11] = '{4'b1110, 1'b1, 2'd3, 4'b0001};
    tbl[12] = '{4'b0110, 1'b1, 2'd3, 4'b0001};  // no preemption by higher priority
    tbl[13] = '{4'b0111, 1'b1, 2'd0, 4'b1000};
    tbl[14] = '{4'b1111, 1'b0, 2'd0, 4'b0000};

    // reset state
    rst = 1'b1; req4 = 4'b1111; req5 = 5'b11111;
    step();
    live = 1'b1;
    check("rst_valid", 32'(v0), 0);
    check("rst_idx", 32'(i0), 0);
    check("rst_onehot", 32'(o0), 0);
    req4 = 4'b0000; req5 = 5'b00000;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_hold_u0", {v0, i0, o0}, 0);
      check("rst_hold_u1", {v1, i1, o1}, 0);
    end
    rst = 1'b0;

    // table: fixed priority / legacy encoding
    for (int t = 0; t < 15; t++) begin
      req4 = tbl[t].req;
      step();
      check($sformatf("tbl%0d_valid", t), 32'(v0), 32'(tbl[t].v));
      check($sformatf("tbl%0d_idx", t), 32'(i0), 32'(tbl[t].idx));
      check($sformatf("tbl%0d_onehot", t), 32'(o0), 32'(tbl[t].oh));
    end

    // round-robin with hold limit 4, everybody requesting
    rst = 1'b1; step(); rst = 1'b0;
    req4 = 4'b0000;
    for (int c = 0; c < 17; c++) begin
      step();
      check($sformatf("rr_hold_c%0d_valid", c), 32'(v1), 1);
      check($sformatf("rr_hold_c%0d_idx", c), 32'(i1), 32'((c / 4) % 4));
    end

    // release without bubble in round-robin mode
    rst = 1'b1; req4 = 4'b1111; step(); rst = 1'b0;
    req4 = 4'b0111; step();
    check("rr_rel_first_idx", 32'(i1), 0);
    req4 = 4'b1010; step();
    check("rr_rel_valid", 32'(v1), 1);
    check("rr_rel_idx", 32'(i1), 1);
    check("rr_rel_onehot", 32'(o1), 32'(4'b0100));

    // hold limit 2 with a lone requester
    rst = 1'b1; step(); rst = 1'b0;
    req4 = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("lone_c%0d_idx", c), {31'(v2), i2[0]}, 32'h3);
      check($sformatf("lone_c%0d_hold", c), 32'(u2.hold_cnt), 32'(c % 2));
    end
    req4 = 4'b0011;
    begin
      bit moved;
      moved = 1'b0;
      for (int c = 0; c < 2 && !moved; c++) begin
        step();
        if (v2 && i2 == 2'd0) moved = 1'b1;
      end
      check("lone_moves_to_idx0", 32'(moved), 1);
    end

    // reset in the middle of a grant
    rst = 1'b1; step(); rst = 1'b0;
    req4 = 4'b1101; step();
    check("midrst_pre_idx", {31'(v1), 1'b0} | 32'(i1), 32'h2 | 32'h2);
    rst = 1'b1; req4 = 4'b0000; step();
    check("midrst_valid", 32'(v1), 0);
    check("midrst_idx", 32'(i1), 0);
    check("midrst_onehot", 32'(o1), 0);
    check("midrst_rr_ptr", 32'(u1.rr_ptr), 0);
    rst = 1'b0; step();
    check("midrst_after_valid", 32'(v1), 1);
    check("midrst_after_idx", 32'(i1), 0);

    // randomized against the reference model (all five configurations)
    rst = 1'b1; step(); rst = 1'b0;
    for (int id = 0; id < 5; id++) mdl[id] = '{0, 0, 0, 0};
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          req4 = 4'($urandom);
          req5 = 5'($urandom);
        end else begin
          req4 = 4'($urandom | $urandom);
          req5 = 5'($urandom | $urandom);
        end
      end
      step();
      for (int id = 0; id < 5; id++)
        mdl[id] = ref_next(mdl[id], p_n[id], p_mode[id], p_hold[id],
                           (id < 3) ? {4'hf, req4} : {3'h7, req5}, rst);
      cmp(0, v0, 3'(i0), 8'(o0));
      cmp(1, v1, 3'(i1), 8'(o1));
      cmp(2, v2, 3'(i2), 8'(o2));
      cmp(3, v3, i3, 8'(o3));
      cmp(4, v4, i4, 8'(o4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
